generador_morse: RTL and testbench
==================================

Name: generador_morse

Overview:
Downstream consumer of the 7-bit character path in the Morse transmitter. Accepts one ASCII character per valid/ready handshake and converts it to a timed on/off keying signal (dot, dash, gaps) on `salida`. Also reports unsupported characters. Sits between character selection/comparison logic and the output driver (LED/buzzer).

Parameters:
- UNIT_CYCLES, default 12000000: clock cycles per Morse time unit (120 ms at 100 MHz). Must be ≥1.
- TMR_W, default 26: timer width. Must hold 4*UNIT_CYCLES-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- caracter  in  7  ASCII character to transmit.
- valido  in  1  `caracter` valid.
- listo  out  1  ready to accept; high only in IDLE.
- salida  out  1  Morse key output; 1 = tone/on.
- ocupado  out  1  high in any state other than IDLE.
- error  out  1  one-cycle pulse when an unsupported character is accepted.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports `clk`, `rst_n`).
- Reset values: salida=0, listo=1, ocupado=0, error=0, state=IDLE, timer=0. Reset mid-transmission forces salida=0 immediately, asynchronously, and aborts the character.
- Handshake: a character is accepted on a rising edge with valido=1 and listo=1. Inputs are ignored while listo=0; the producer holds them.
- Lookup, combinational:
  - Supported: 'A'-'Z', 'a'-'z' (case-folded), '0'-'9', space (0x20).
  - Result per character: len[2:0] (1-5), pat[4:0] (pat[0] = first symbol, 1 = dash), flags ok and esp.
  - Registered into len_r, pat_r in the accept cycle.
- States:
  - IDLE: listo=1. On accept:
    - letter/digit -> MARCA
    - space -> PAUSA_ESP
    - unsupported -> IDLE, with error=1 for the following cycle.
  - MARCA: salida=1 for UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash). Then -> PAUSA_SIMB if symbols remain, else PAUSA_CAR.
  - PAUSA_SIMB: salida=0 for UNIT_CYCLES. Shift pat_r right, decrement len_r, then -> MARCA.
  - PAUSA_CAR: salida=0 for 3*UNIT_CYCLES, then -> IDLE.
  - PAUSA_ESP: salida=0 for 4*UNIT_CYCLES, then -> IDLE. Combined with the preceding 3-unit gap this gives the 7-unit word gap.
- Timer:
  - Loaded with N*UNIT_CYCLES-1 on each state entry; decrements once per cycle.
  - State advances on the cycle the timer reaches 0, so each state lasts exactly N*UNIT_CYCLES cycles.
- Latency and output timing:
  - salida rises on the first cycle after the accept edge.
  - salida is registered (no glitches).
- Back-to-back characters: listo returns high on the first cycle in IDLE. A character already presented is accepted on that edge, with no extra idle cycle.
- error never asserts together with salida=1. listo=0 during the error pulse cycle is not required; the pulse happens in IDLE with listo=1.

Decomposition:
- Package morse_pkg:
  - State encoding: IDLE, MARCA, PAUSA_SIMB, PAUSA_CAR, PAUSA_ESP.
  - Unit multipliers: DOT=1, DASH=3, GAP_SIMB=1, GAP_CAR=3, GAP_ESP=4.
  - Constants ASCII_ESPACIO=7'h20 and pattern width 5.
- Sub-module tabla_morse: combinational, caracter[6:0] -> {ok, esp, len[2:0], pat[4:0]}. It holds the full A-Z / 0-9 table and the case fold, and is unit-tested on its own.

Test Plan (UNIT_CYCLES=4):
- 'E' (0x45): salida high 4 cycles starting the cycle after accept, then low 12, then listo=1; total 16 cycles busy.
- 'A' (0x41): salida pattern 4 high, 4 low, 12 high, 12 low; listo back after 32 cycles. 'a' (0x61) gives an identical waveform.
- '0' (0x30): five 12-cycle marks separated by 4-cycle gaps, then 12 low; 88 cycles total.
- ' ' (0x20): salida stays 0 for 16 cycles, listo=0 throughout, then 1. '#' (0x23): error=1 for exactly one cycle, salida stays 0, listo=1 next cycle.
- Back-to-back 'T','E' with valido held high: T mark 12, gap 12, then E mark begins on the next cycle. Changing caracter while listo=0 has no effect.
- rst_n low during the second cycle of 'T' mark: salida=0 in the same cycle (async), listo=1. After release, a new 'E' is transmitted normally.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse generator: FSM states, timing
// multipliers (in Morse units) and the character lookup result.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARCA,
        PAUSA_SIMB,
        PAUSA_CAR,
        PAUSA_ESP
    } estado_e;

    localparam int unsigned DOT      = 1;
    localparam int unsigned DASH     = 3;
    localparam int unsigned GAP_SIMB = 1;
    localparam int unsigned GAP_CAR  = 3;
    localparam int unsigned GAP_ESP  = 4;

    localparam logic [6:0] ASCII_ESPACIO = 7'h20;
    localparam int         PAT_W         = 5;

    // pat[0] is the first symbol to send; 1 = dash, 0 = dot.
    typedef struct packed {
        logic             ok;
        logic             esp;
        logic [2:0]       len;
        logic [PAT_W-1:0] pat;
    } simbolo_t;

endpackage

// File: rtl/tabla_morse.sv
// Combinational ASCII -> Morse lookup with case folding. Space is reported
// as supported (ok=1, esp=1) but carries no symbols.
module tabla_morse
    import morse_pkg::*;
(
    input  logic [6:0] caracter_i,
    output simbolo_t   simbolo_o
);

    logic [6:0]       letra;
    logic [2:0]       len;
    logic [PAT_W-1:0] seq;

    // seq is written in reading order (first symbol in the MSB) for legibility;
    // it is bit-reversed below so pat[0] is the first symbol.
    always_comb begin
        letra = caracter_i;
        if (caracter_i >= 7'h61 && caracter_i <= 7'h7A) begin
            letra = caracter_i - 7'h20;
        end
        len = 3'd0;
        seq = 5'b00000;
        case (letra)
            7'h41: {len, seq} = {3'd2, 5'b01000};
            7'h42: {len, seq} = {3'd4, 5'b10000};
            7'h43: {len, seq} = {3'd4, 5'b10100};
            7'h44: {len, seq} = {3'd3, 5'b10000};
            7'h45: {len, seq} = {3'd1, 5'b00000};
            7'h46: {len, seq} = {3'd4, 5'b00100};
            7'h47: {len, seq} = {3'd3, 5'b11000};
            7'h48: {len, seq} = {3'd4, 5'b00000};
            7'h49: {len, seq} = {3'd2, 5'b00000};
            7'h4A: {len, seq} = {3'd4, 5'b01110};
            7'h4B: {len, seq} = {3'd3, 5'b10100};
            7'h4C: {len, seq} = {3'd4, 5'b01000};
            7'h4D: {len, seq} = {3'd2, 5'b11000};
            7'h4E: {len, seq} = {3'd2, 5'b10000};
            7'h4F: {len, seq} = {3'd3, 5'b11100};
            7'h50: {len, seq} = {3'd4, 5'b01100};
            7'h51: {len, seq} = {3'd4, 5'b11010};
            7'h52: {len, seq} = {3'd3, 5'b01000};
            7'h53: {len, seq} = {3'd3, 5'b00000};
            7'h54: {len, seq} = {3'd1, 5'b10000};
            7'h55: {len, seq} = {3'd3, 5'b00100};
            7'h56: {len, seq} = {3'd4, 5'b00010};
            7'h57: {len, seq} = {3'd3, 5'b01100};
            7'h58: {len, seq} = {3'd4, 5'b10010};
            7'h59: {len, seq} = {3'd4, 5'b10110};
            7'h5A: {len, seq} = {3'd4, 5'b11000};
            7'h30: {len, seq} = {3'd5, 5'b11111};
            7'h31: {len, seq} = {3'd5, 5'b01111};
            7'h32: {len, seq} = {3'd5, 5'b00111};
            7'h33: {len, seq} = {3'd5, 5'b00011};
            7'h34: {len, seq} = {3'd5, 5'b00001};
            7'h35: {len, seq} = {3'd5, 5'b00000};
            7'h36: {len, seq} = {3'd5, 5'b10000};
            7'h37: {len, seq} = {3'd5, 5'b11000};
            7'h38: {len, seq} = {3'd5, 5'b11100};
            7'h39: {len, seq} = {3'd5, 5'b11110};
            default: {len, seq} = {3'd0, 5'b00000};
        endcase

        simbolo_o.esp = (letra == ASCII_ESPACIO);
        simbolo_o.ok  = (len != 3'd0) || (letra == ASCII_ESPACIO);
        simbolo_o.len = len;
        for (int i = 0; i < PAT_W; i++) begin
            simbolo_o.pat[i] = seq[PAT_W-1-i];
        end
    end

endmodule

// File: rtl/generador_morse.sv
// Converts one accepted ASCII character into timed Morse keying on salida.
// All outputs are registered; reset asynchronously silences the key.
module generador_morse
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12000000,
    parameter int unsigned TMR_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] caracter,
    input  logic       valido,
    output logic       listo,
    output logic       salida,
    output logic       ocupado,
    output logic       error
);

    localparam logic [TMR_W-1:0] T_DOT      = TMR_W'(DOT * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_DASH     = TMR_W'(DASH * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP_SIMB = TMR_W'(GAP_SIMB * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP_CAR  = TMR_W'(GAP_CAR * UNIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP_ESP  = TMR_W'(GAP_ESP * UNIT_CYCLES - 1);

    estado_e          estado_q;
    logic [TMR_W-1:0] timer_q;
    logic [2:0]       len_q;
    logic [PAT_W-1:0] pat_q;
    logic             listo_q;
    logic             salida_q;
    logic             ocupado_q;
    logic             error_q;

    simbolo_t         simbolo;
    logic [PAT_W-1:0] patNext_d;

    tabla_morse u_tabla (
        .caracter_i (caracter),
        .simbolo_o  (simbolo)
    );

    assign patNext_d = pat_q >> 1;

    // Every state loads its full duration minus one on entry and leaves on the
    // cycle the timer hits zero, so durations are exact multiples of the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            timer_q   <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            listo_q   <= 1'b1;
            salida_q  <= 1'b0;
            ocupado_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (valido) begin
                        if (simbolo.esp) begin
                            estado_q  <= PAUSA_ESP;
                            timer_q   <= T_GAP_ESP;
                            listo_q   <= 1'b0;
                            ocupado_q <= 1'b1;
                        end else if (simbolo.ok) begin
                            estado_q  <= MARCA;
                            timer_q   <= simbolo.pat[0] ? T_DASH : T_DOT;
                            len_q     <= simbolo.len;
                            pat_q     <= simbolo.pat;
                            salida_q  <= 1'b1;
                            listo_q   <= 1'b0;
                            ocupado_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                MARCA: begin
                    if (timer_q == '0) begin
                        salida_q <= 1'b0;
                        if (len_q > 3'd1) begin
                            estado_q <= PAUSA_SIMB;
                            timer_q  <= T_GAP_SIMB;
                        end else begin
                            estado_q <= PAUSA_CAR;
                            timer_q  <= T_GAP_CAR;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                PAUSA_SIMB: begin
                    if (timer_q == '0) begin
                        estado_q <= MARCA;
                        pat_q    <= patNext_d;
                        len_q    <= len_q - 3'd1;
                        timer_q  <= patNext_d[0] ? T_DASH : T_DOT;
                        salida_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                PAUSA_CAR, PAUSA_ESP: begin
                    if (timer_q == '0) begin
                        estado_q  <= IDLE;
                        listo_q   <= 1'b1;
                        ocupado_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    estado_q  <= IDLE;
                    salida_q  <= 1'b0;
                    listo_q   <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign listo   = listo_q;
    assign salida  = salida_q;
    assign ocupado = ocupado_q;
    assign error   = error_q;

endmodule

// File: tb/tb_generador_morse.sv
// Randomized self-checking bench for generador_morse; expected keying is built
// from dot/dash strings and Morse unit timing rules.
module tb_generador_morse;

    localparam int U = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] caracter;
    logic       valido;
    logic       listo;
    logic       salida;
    logic       ocupado;
    logic       error;

    int checks = 0;
    int errors = 0;
    bit expQ[$];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----."};

    generador_morse #(.UNIT_CYCLES(U), .TMR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .caracter (caracter),
        .valido   (valido),
        .listo    (listo),
        .salida   (salida),
        .ocupado  (ocupado),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic string morseOf(input logic [6:0] c);
        int v = int'(c);
        if (v >= 65 && v <= 90) return letters[v-65];
        if (v >= 97 && v <= 122) return letters[v-97];
        if (v >= 48 && v <= 57) return digits[v-48];
        return "";
    endfunction

    // Expected salida per cycle after the accept edge; empty if unsupported.
    function automatic void buildWave(input logic [6:0] c);
        string s;
        expQ.delete();
        if (c == 7'h20) begin
            repeat (4*U) expQ.push_back(1'b0);
            return;
        end
        s = morseOf(c);
        if (s.len() == 0) return;
        for (int k = 0; k < s.len(); k++) begin
            repeat ((s[k] == 8'h2D ? 3 : 1) * U) expQ.push_back(1'b1);
            if (k < s.len() - 1) repeat (U) expQ.push_back(1'b0);
        end
        repeat (3*U) expQ.push_back(1'b0);
    endfunction

    task automatic applyStimulus(input logic [6:0] c, input bit hold);
        int n = 0;
        while (listo !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("listoWait", listo, 1);
        caracter = c;
        valido   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valido = 1'b0;
    endtask

    task automatic checkWave(input logic [6:0] c);
        buildWave(c);
        if (expQ.size() == 0) begin
            @(negedge clk);
            checkOutput($sformatf("errPulse[%02h]", c), error, 1);
            checkOutput($sformatf("errListo[%02h]", c), listo, 1);
            checkOutput($sformatf("errSalida[%02h]", c), salida, 0);
            @(negedge clk);
            checkOutput($sformatf("errEnd[%02h]", c), error, 0);
            checkOutput($sformatf("errListo2[%02h]", c), listo, 1);
            return;
        end
        foreach (expQ[i]) begin
            @(negedge clk);
            checkOutput($sformatf("salida[%02h]#%0d", c, i), salida, expQ[i]);
            checkOutput($sformatf("listo[%02h]#%0d", c, i), listo, 0);
            checkOutput($sformatf("ocupado[%02h]#%0d", c, i), ocupado, 1);
            checkOutput($sformatf("error[%02h]#%0d", c, i), error, 0);
        end
        @(negedge clk);
        checkOutput($sformatf("endListo[%02h]", c), listo, 1);
        checkOutput($sformatf("endOcupado[%02h]", c), ocupado, 0);
        checkOutput($sformatf("endSalida[%02h]", c), salida, 0);
    endtask

    logic [6:0] pool[$] = '{7'h45, 7'h41, 7'h61, 7'h30, 7'h20, 7'h23, 7'h5A, 7'h7A,
                            7'h39, 7'h51, 7'h6A, 7'h35, 7'h40, 7'h5B, 7'h7B, 7'h2F};

    initial begin
        logic [6:0] c;
        logic [6:0] nxt;
        rst_n    = 1'b0;
        caracter = 7'h00;
        valido   = 1'b0;
        #12;
        checkOutput("rstSalida", salida, 0);
        checkOutput("rstListo", listo, 1);
        checkOutput("rstOcupado", ocupado, 0);
        checkOutput("rstError", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(7'h45, 0); checkWave(7'h45);
        applyStimulus(7'h41, 0); checkWave(7'h41);
        applyStimulus(7'h61, 0); checkWave(7'h61);
        applyStimulus(7'h30, 0); checkWave(7'h30);
        applyStimulus(7'h20, 0); checkWave(7'h20);
        applyStimulus(7'h23, 0); checkWave(7'h23);

        // Back-to-back with valido held; caracter changes while busy.
        applyStimulus(7'h54, 1);
        caracter = 7'h45;
        checkWave(7'h54);
        @(posedge clk);
        #1;
        valido = 1'b0;
        checkWave(7'h45);

        // Asynchronous reset in the second cycle of a mark.
        applyStimulus(7'h54, 0);
        @(negedge clk);
        checkOutput("preRstSalida", salida, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstSalida", salida, 0);
        checkOutput("asyncRstListo", listo, 1);
        checkOutput("asyncRstOcupado", ocupado, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(7'h45, 0); checkWave(7'h45);

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1)
                c = pool[$urandom_range(0, pool.size() - 1)];
            else
                c = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0 && morseOf(c).len() != 0) begin
                nxt = pool[$urandom_range(0, 3)];
                applyStimulus(c, 1);
                caracter = nxt;
                checkWave(c);
                @(posedge clk);
                #1;
                valido = 1'b0;
                checkWave(nxt);
            end else begin
                applyStimulus(c, 0);
                checkWave(c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
